// File: rtl/sweep_addr_gen.sv
// -----------------------------------------------------------------------------
// sweep_addr_gen
//
// Turns a sweep trigger into one A-line of RAM writes. A rising edge of trig,
// seen while enable is high and the block is idle, optionally waits `delay`
// cycles, then writes NSAMPLES consecutive addresses starting at 0. The block
// then pulses line_done and flips the ping-pong bank. Edges that arrive while
// a line is in flight are dropped and latch the sticky overrun flag.
//
// Optional build macro:
//   TRIG_SYNC_EN  - pass trig through a two-flop synchroniser before edge
//                   detection (trig may then be asynchronous; +2 cycles).
//
// Parameters:
//   ADDR_W    - width of the sample write address
//   NSAMPLES  - samples written per line (1 .. 2**ADDR_W)
//   DLY_W     - width of the trigger-to-acquisition delay
//
// Ports:
//   clock      in   sole clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   enable     in   arms acceptance of new triggers
//   trig       in   sweep trigger (level, rising edge starts a line)
//   delay      in   cycles from accepted edge to first write
//   clr_ovr    in   synchronous clear of overrun
//   addr       out  RAM write address (0 whenever wren is low)
//   wren       out  RAM write enable
//   bank       out  ping-pong buffer select for the line being written
//   busy       out  high while waiting out the delay or acquiring
//   line_done  out  one-cycle pulse after the last write of a line
//   overrun    out  sticky: a trigger was lost while busy
// -----------------------------------------------------------------------------
module sweep_addr_gen #(
  parameter int ADDR_W   = 11,
  parameter int NSAMPLES = 1024,
  parameter int DLY_W    = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              trig,
  input  logic [DLY_W-1:0]  delay,
  input  logic              clr_ovr,
  output logic [ADDR_W-1:0] addr,
  output logic              wren,
  output logic              bank,
  output logic              busy,
  output logic              line_done,
  output logic              overrun
);

  generate
    if (NSAMPLES < 1 || NSAMPLES > (1 << ADDR_W)) begin : g_bad_nsamples
      $error("sweep_addr_gen: NSAMPLES must be in 1 .. 2**ADDR_W");
    end
  endgenerate

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DELAY = 2'd1;
  localparam logic [1:0] S_ACQ   = 2'd2;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NSAMPLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [DLY_W-1:0]  DLY_ONE   = DLY_W'(1);

  logic [1:0]        r_state;
  logic [DLY_W-1:0]  r_dly_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wren;
  logic              r_bank;
  logic              r_busy;
  logic              r_line_done;
  logic              r_overrun;
  logic              r_trig_q;
  logic              r_armed;

  logic              w_trig;      // trigger as seen by the edge detector
  logic              w_trig_vld;  // w_trig reflects a real post-reset sample
  logic              w_edge;
  logic              w_start;
  logic              w_drop;

`ifdef TRIG_SYNC_EN
  logic [1:0] r_sync;
  logic [1:0] r_sync_vld;

  // Two-flop synchroniser. The parallel valid chain marks when the second
  // stage holds a genuine sample of trig rather than its reset value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync     <= 2'b00;
      r_sync_vld <= 2'b00;
    end else begin
      r_sync     <= {r_sync[0], trig};
      r_sync_vld <= {r_sync_vld[0], 1'b1};
    end
  end

  assign w_trig     = r_sync[1];
  assign w_trig_vld = r_sync_vld[1];
`else
  assign w_trig     = trig;
  assign w_trig_vld = 1'b1;
`endif

  // r_armed stays low after reset until trig has been seen low, so a trigger
  // that is already high when reset releases cannot masquerade as an edge.
  assign w_edge  = w_trig & ~r_trig_q & r_armed;
  assign w_start = w_edge & enable & (r_state == S_IDLE);
  assign w_drop  = w_edge & (r_state != S_IDLE);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_trig_q <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_trig_q <= w_trig;
      r_armed  <= r_armed | (w_trig_vld & ~w_trig);
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clr_ovr) begin
      r_overrun <= 1'b0;
    end
  end

  // Line sequencer. Outputs are registered alongside the state so they change
  // in the same cycle as the state they describe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_dly_cnt   <= '0;
      r_addr      <= '0;
      r_wren      <= 1'b0;
      r_bank      <= 1'b0;
      r_busy      <= 1'b0;
      r_line_done <= 1'b0;
    end else begin
      r_line_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_busy <= 1'b1;
            if (delay == '0) begin
              r_state <= S_ACQ;
              r_wren  <= 1'b1;
              r_addr  <= '0;
            end else begin
              r_state   <= S_DELAY;
              r_dly_cnt <= delay;
            end
          end
        end

        S_DELAY: begin
          // Counter value d in the first DELAY cycle gives exactly d DELAY
          // cycles before the first write.
          r_dly_cnt <= r_dly_cnt - DLY_ONE;
          if (r_dly_cnt == DLY_ONE) begin
            r_state <= S_ACQ;
            r_wren  <= 1'b1;
            r_addr  <= '0;
          end
        end

        S_ACQ: begin
          if (r_addr == ADDR_LAST) begin
            r_state     <= S_IDLE;
            r_wren      <= 1'b0;
            r_addr      <= '0;
            r_busy      <= 1'b0;
            r_line_done <= 1'b1;
            r_bank      <= ~r_bank;
          end else begin
            r_addr <= r_addr + ADDR_ONE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_wren  <= 1'b0;
          r_addr  <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign addr      = r_addr;
  assign wren      = r_wren;
  assign bank      = r_bank;
  assign busy      = r_busy;
  assign line_done = r_line_done;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_sweep_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_sweep_addr_gen
//
// Self-checking bench for sweep_addr_gen (ADDR_W=4, NSAMPLES=8, DLY_W=8).
// Every cycle the DUT outputs are compared with a line-schedule model: an
// accepted trigger at cycle T with delay d owns cycles T+1 .. T+d+NSAMPLES,
// writes during the last NSAMPLES of them and completes one cycle later.
// Directed scenarios exercise the documented corner cases, followed by a
// randomised phase with occasional mid-run resets. Honours TRIG_SYNC_EN.
// -----------------------------------------------------------------------------
module tb_sweep_addr_gen;

  localparam int ADDR_W = 4;
  localparam int NS     = 8;
  localparam int DLY_W  = 8;
  localparam int HIST   = 8192;
`ifdef TRIG_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic              clock = 1'b0;
  logic              reset_n;
  logic              enable;
  logic              trig;
  logic [DLY_W-1:0]  delay;
  logic              clr_ovr;
  logic [ADDR_W-1:0] addr;
  logic              wren;
  logic              bank;
  logic              busy;
  logic              line_done;
  logic              overrun;

  always #5 clock = ~clock;

  sweep_addr_gen #(
    .ADDR_W  (ADDR_W),
    .NSAMPLES(NS),
    .DLY_W   (DLY_W)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .enable   (enable),
    .trig     (trig),
    .delay    (delay),
    .clr_ovr  (clr_ovr),
    .addr     (addr),
    .wren     (wren),
    .bank     (bank),
    .busy     (busy),
    .line_done(line_done),
    .overrun  (overrun)
  );

  int n_cmp   = 0;
  int n_err   = 0;
  int cyc     = 0;
  int rst_cyc = 0;

  bit trig_hist[HIST];

  // Reference model state: the one line currently scheduled, plus flags.
  bit m_line;
  bit m_bank;
  bit m_ovr;
  bit m_armed;
  int m_acc;
  int m_first;
  int m_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Trigger level seen by the edge detector in cycle k (0 before any real
  // post-reset sample has reached it).
  function automatic bit eff(int k);
    if (k - SYNC_LAT < rst_cyc || k - SYNC_LAT >= HIST) return 1'b0;
    return trig_hist[k - SYNC_LAT];
  endfunction

  function automatic bit sample_valid(int k);
    return (k - SYNC_LAT) >= rst_cyc;
  endfunction

  task automatic model_reset();
    m_line  = 1'b0;
    m_bank  = 1'b0;
    m_ovr   = 1'b0;
    m_armed = 1'b0;
    m_acc   = 0;
    m_first = 0;
    m_last  = 0;
  endtask

  // Called at the falling edge of cycle `cyc`: check that cycle's outputs,
  // drive its inputs, advance the model, move to the next falling edge.
  task automatic step(input bit t, input bit en, input int d, input bit clr);
    bit exp_done, exp_wren, exp_busy, e;
    int exp_addr;
    exp_done = 1'b0;
    if (m_line && cyc == m_last + 1) begin
      exp_done = 1'b1;
      m_bank   = ~m_bank;
      m_line   = 1'b0;
    end
    exp_wren = m_line && cyc >= m_first && cyc <= m_last;
    exp_addr = exp_wren ? cyc - m_first : 0;
    exp_busy = m_line && cyc > m_acc;

    check("wren",      32'(wren),      32'(exp_wren));
    check("addr",      32'(addr),      exp_addr);
    check("busy",      32'(busy),      32'(exp_busy));
    check("line_done", 32'(line_done), 32'(exp_done));
    check("bank",      32'(bank),      32'(m_bank));
    check("overrun",   32'(overrun),   32'(m_ovr));

    trig    = t;
    enable  = en;
    delay   = DLY_W'(d);
    clr_ovr = clr;
    if (cyc < HIST) trig_hist[cyc] = t;

    e = eff(cyc) && !eff(cyc - 1) && m_armed;
    if (e && exp_busy)  m_ovr = 1'b1;
    else if (clr)       m_ovr = 1'b0;
    if (e && en && !exp_busy) begin
      m_line  = 1'b1;
      m_acc   = cyc;
      m_first = cyc + 1 + d;
      m_last  = m_first + NS - 1;
    end
    if (sample_valid(cyc) && !eff(cyc)) m_armed = 1'b1;

    @(negedge clock);
    cyc++;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_addr",      32'(addr),      0);
    check("rst_wren",      32'(wren),      0);
    check("rst_bank",      32'(bank),      0);
    check("rst_busy",      32'(busy),      0);
    check("rst_line_done", 32'(line_done), 0);
    check("rst_overrun",   32'(overrun),   0);
    @(negedge clock); cyc++;
    @(negedge clock); cyc++;
    reset_n = 1'b1;
    rst_cyc = cyc;
    model_reset();
  endtask

  // Raw trig rise to first observed write, in cycles.
  task automatic measure_latency(input int d, input string tag);
    int c0, lat;
    repeat (3) step(1'b0, 1'b1, d, 1'b0);
    c0 = cyc;
    step(1'b1, 1'b1, d, 1'b0);
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (wren === 1'b1) begin
        lat = cyc - c0;
        break;
      end
      step(1'b1, 1'b1, d, 1'b0);
    end
    check(tag, lat, 1 + d + SYNC_LAT);
    check({tag, "_addr"}, 32'(addr), 0);
    repeat (20) step(1'b0, 1'b1, d, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    trig    = 1'b0;
    enable  = 1'b0;
    delay   = '0;
    clr_ovr = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check("init_addr",      32'(addr),      0);
    check("init_wren",      32'(wren),      0);
    check("init_bank",      32'(bank),      0);
    check("init_busy",      32'(busy),      0);
    check("init_line_done", 32'(line_done), 0);
    check("init_overrun",   32'(overrun),   0);
    reset_n = 1'b1;
    cyc     = 0;
    rst_cyc = 0;

    // delay 0, single edge: 8 writes, line_done, bank 0 -> 1
    repeat (3) step(1'b0, 1'b1, 0, 1'b0);
    repeat (15) step(1'b1, 1'b1, 0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 0, 1'b0);
    check("s1_bank_after", 32'(bank), 1);

    // first-write latency for delay 5 and delay 2
    measure_latency(5, "lat_d5");
    measure_latency(2, "lat_d2");

    // edge ignored while disabled, no overrun
    step(1'b1, 1'b0, 0, 1'b0);
    repeat (12) step(1'b0, 1'b0, 0, 1'b0);
    check("dis_overrun", 32'(overrun), 0);

    // second edge while addr=3: dropped, overrun set, single bank toggle
    step(1'b1, 1'b1, 0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 0, 1'b0);
    step(1'b1, 1'b1, 0, 1'b0);
    repeat (16) step(1'b0, 1'b1, 0, 1'b0);
    check("ovr_set", 32'(overrun), 1);
    step(1'b0, 1'b1, 0, 1'b1);
    repeat (2) step(1'b0, 1'b1, 0, 1'b0);
    check("ovr_cleared", 32'(overrun), 0);

    // dropped edge coinciding with clr_ovr: the set wins
    step(1'b1, 1'b1, 0, 1'b0);
    repeat (2) step(1'b0, 1'b1, 0, 1'b0);
    step(1'b1, 1'b1, 0, 1'b1);
    repeat (14) step(1'b0, 1'b1, 0, 1'b0);
    check("ovr_set_wins", 32'(overrun), 1);
    step(1'b0, 1'b1, 0, 1'b1);

    // edge in the line_done cycle starts the next line immediately
    repeat (3) step(1'b0, 1'b1, 0, 1'b0);
    step(1'b1, 1'b1, 0, 1'b0);
    repeat (8) step(1'b0, 1'b1, 0, 1'b0);
    step(1'b1, 1'b1, 0, 1'b0);
    repeat (15) step(1'b0, 1'b1, 0, 1'b0);

    // enable dropped mid-line does not abort it
    step(1'b1, 1'b1, 3, 1'b0);
    repeat (14) step(1'b0, 1'b0, 3, 1'b0);

    // reset at addr=4 with trig held high through release
    repeat (3) step(1'b0, 1'b1, 0, 1'b0);
    step(1'b1, 1'b1, 0, 1'b0);
    repeat (SYNC_LAT + 4) step(1'b1, 1'b1, 0, 1'b0);
    check("pre_rst_addr", 32'(addr), 4);
    do_reset();
    repeat (15) step(1'b1, 1'b1, 0, 1'b0);
    check("held_trig_no_start", 32'(busy), 0);
    repeat (2) step(1'b0, 1'b1, 0, 1'b0);
    repeat (15) step(1'b1, 1'b1, 0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 0, 1'b0);

    // randomised traffic
    begin
      bit t;
      t = 1'b0;
      for (int i = 0; i < 1500; i++) begin
        int d;
        if ($urandom_range(0, 5) == 0) t = ~t;
        d = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 10));
        if ($urandom_range(0, 499) == 0) do_reset();
        step(t, $urandom_range(0, 9) != 0, d, $urandom_range(0, 19) == 0);
      end
    end
    repeat (30) step(1'b0, 1'b1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sweep_addr_gen.md
SWEEP_ADDR_GEN -- requirements
Module: sweep_addr_gen

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 11: width of the sample write address.
REQ-002 The block SHALL have parameter NSAMPLES, default 1024: samples written per A-line; elaboration SHALL fail if NSAMPLES < 1 or NSAMPLES > 2**ADDR_W.
REQ-003 The block SHALL have parameter DLY_W, default 8: width of the trigger-to-acquisition delay.
REQ-004 The block SHALL have port clock, input, 1: sole clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-006 The block SHALL have port enable, input, 1: arms acceptance of new triggers.
REQ-007 The block SHALL have port trig, input, 1: sweep trigger, level; rising edge starts a line.
REQ-008 The block SHALL have port delay, input, DLY_W: cycles from accepted edge to first write, sampled at acceptance.
REQ-009 The block SHALL have port clr_ovr, input, 1: synchronous clear of overrun.
REQ-010 The block SHALL have port addr, output, ADDR_W: RAM write address.
REQ-011 The block SHALL have port wren, output, 1: RAM write enable.
REQ-012 The block SHALL have port bank, output, 1: ping-pong buffer select for the line being written.
REQ-013 The block SHALL have port busy, output, 1: high in DELAY or ACQ.
REQ-014 The block SHALL have port line_done, output, 1: one-cycle pulse at end of line.
REQ-015 The block SHALL have port overrun, output, 1: sticky flag for a trigger lost while busy.

Function
REQ-016 The block SHALL register trig into trig_q every cycle; edge = trig AND NOT trig_q, computed from the registered path.
REQ-017 The block SHALL implement states IDLE, DELAY and ACQ; all outputs SHALL be registered.
REQ-018 In IDLE, on edge with enable=1, the block SHALL go to ACQ if delay=0, else to DELAY with a down-counter loaded with delay.
REQ-019 In IDLE, an edge with enable=0 SHALL be ignored, with no overrun.
REQ-020 In DELAY, the counter SHALL decrement each cycle, and the block SHALL go to ACQ in the cycle after it reaches 1.
REQ-021 With edge detected in cycle T, the first wren=1 SHALL occur in cycle T+1+delay with addr=0.
REQ-022 In ACQ, wren SHALL be 1 and addr SHALL step 0,1,...,NSAMPLES-1, one per cycle, for exactly NSAMPLES cycles, then return to IDLE.
REQ-023 When wren=0, addr SHALL be 0.
REQ-024 In the cycle after the last write, line_done SHALL pulse once and bank SHALL toggle.
REQ-025 An edge while busy SHALL be dropped, the current line SHALL continue unaffected, and overrun SHALL set.
REQ-026 An edge in the same cycle as line_done SHALL be accepted, since the block is in IDLE that cycle.
REQ-027 Deasserting enable mid-line SHALL NOT abort the line; it SHALL block only the next start.
REQ-028 clr_ovr SHALL clear overrun next cycle; a simultaneous new overrun SHALL win, leaving overrun=1.
REQ-029 Address arithmetic SHALL be ADDR_W-bit unsigned and SHALL never wrap within a line.

Reset
REQ-030 reset_n=0 SHALL immediately force state IDLE and addr=0, wren=0, bank=0, busy=0, line_done=0, overrun=0, with trig_q, synchroniser flops and counters cleared.
REQ-031 Reset asserted mid-line SHALL abort the line, and no line_done SHALL be issued.
REQ-032 After release, the block SHALL require a fresh rising edge of trig; a trig already held high SHALL NOT start a line.

Configuration
REQ-033 With macro TRIG_SYNC_EN defined, trig SHALL pass through a two-flop synchroniser before trig_q, adding 2 cycles, so the first write is at T+3+delay relative to the raw edge.
REQ-034 Without TRIG_SYNC_EN, trig SHALL feed trig_q directly, and trig SHALL be synchronous to clock.

Verification (NSAMPLES=8, ADDR_W=4, TRIG_SYNC_EN undefined unless stated)
REQ-035 The bench SHALL cover: delay=0, single trig edge -> wren high 8 cycles, addr 0..7, then line_done pulse and bank 0->1.
REQ-036 The bench SHALL cover: delay=5 -> first wren exactly 6 cycles after edge detection, addr=0.
REQ-037 The bench SHALL cover: second edge at addr=3 -> line completes to addr 7, overrun=1, bank toggles once only; then clr_ovr=1 -> overrun=0.
REQ-038 The bench SHALL cover: edge coincident with line_done -> new line starts, bank=0 again after the second line_done.
REQ-039 The bench SHALL cover: reset_n low at addr=4 -> outputs zero immediately, no line_done; trig held high through release -> no start until trig falls and rises.
REQ-040 The bench SHALL cover: TRIG_SYNC_EN defined, delay=2 -> first wren 5 cycles after raw trig rise.
